fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage pipelined MIPS core. Holds the PC and drives the instruction ROM address, then latches the returned word into the IF/ID pipeline register. Applies stalls from the hazard unit, redirects on taken branches (resolved in EX) and jumps (decoded in ID), and inserts bubbles for the wrong-path instructions.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the five-stage MIPS pipeline.
// Holds the PC, drives the instruction ROM address and fills the IF/ID
// register. Handles hazard stalls, EX-resolved branches and ID-decoded jumps.
// Optional feature macro: FETCH_PERF_CNT_EN adds a saturating counter of
// squashed wrong-path instructions on FlushCount.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    output logic [31:0] InstAddr,
    input  logic [31:0] InstData,
    output logic [31:0] IfIdPC4,
    output logic [31:0] IfIdInst,
    output logic        IfIdValid,
    output logic        FlushEx,
    output logic [15:0] FlushCount
);

    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] pcPlus4;
    logic [31:0] ifIdPc4Next;
    logic [31:0] ifIdInstNext;
    logic        ifIdValidNext;
    logic        jumpTake;

    assign InstAddr = pc;
    assign pcPlus4  = pc + 32'd4;
    assign FlushEx  = BranchTaken & ~Reset;

    // A jump only counts when it sits on a real instruction and nothing of
    // higher priority (branch redirect or stall) claims this edge.
    assign jumpTake = Jump & IfIdValid & ~Stall & ~BranchTaken;

    // Next PC and IF/ID contents; branch beats stall beats jump beats fetch.
    always_comb begin
        pcNext        = pc;
        ifIdPc4Next   = IfIdPC4;
        ifIdInstNext  = IfIdInst;
        ifIdValidNext = IfIdValid;
        if (BranchTaken) begin
            pcNext        = {BranchTarget[31:2], 2'b00};
            ifIdPc4Next   = 32'h0000_0000;
            ifIdInstNext  = 32'h0000_0000;
            ifIdValidNext = 1'b0;
        end else if (Stall) begin
            pcNext        = pc;
        end else if (jumpTake) begin
            pcNext        = {IfIdPC4[31:28], JumpIndex, 2'b00};
            ifIdPc4Next   = 32'h0000_0000;
            ifIdInstNext  = 32'h0000_0000;
            ifIdValidNext = 1'b0;
        end else begin
            pcNext        = pcPlus4;
            ifIdPc4Next   = pcPlus4;
            ifIdInstNext  = InstData;
            ifIdValidNext = 1'b1;
        end
    end

    // PC and IF/ID pipeline register, cleared straight away by reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc        <= RESET_PC;
            IfIdPC4   <= 32'h0000_0000;
            IfIdInst  <= 32'h0000_0000;
            IfIdValid <= 1'b0;
        end else begin
            pc        <= pcNext;
            IfIdPC4   <= ifIdPc4Next;
            IfIdInst  <= ifIdInstNext;
            IfIdValid <= ifIdValidNext;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] flushCnt;
    logic [1:0]  flushInc;
    logic [16:0] flushSum;

    // A branch squashes two wrong-path instructions, a jump squashes one.
    always_comb begin
        flushInc = 2'd0;
        if (BranchTaken) begin
            flushInc = 2'd2;
        end else if (jumpTake) begin
            flushInc = 2'd1;
        end
        flushSum = {1'b0, flushCnt} + {15'd0, flushInc};
    end

    // Saturating squash counter so it never wraps back to a small value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flushCnt <= 16'h0000;
        end else if (flushSum[16]) begin
            flushCnt <= 16'hFFFF;
        end else begin
            flushCnt <= flushSum[15:0];
        end
    end

    assign FlushCount = flushCnt;
`else
    assign FlushCount = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected PC and IF/ID
// contents are pushed when a cycle's stimulus is driven and popped after the
// clock edge to compare against the DUT.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic [31:0] InstAddr;
    logic [31:0] InstData;
    logic [31:0] IfIdPC4;
    logic [31:0] IfIdInst;
    logic        IfIdValid;
    logic        FlushEx;
    logic [15:0] FlushCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic [15:0] cnt;
    } expT;

    expT sb[$];

    logic [31:0] mPc;
    logic [31:0] mPc4;
    logic [31:0] mInst;
    logic        mValid;
    logic [15:0] mCnt;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpIndex(JumpIndex),
        .InstAddr(InstAddr),
        .InstData(InstData),
        .IfIdPC4(IfIdPC4),
        .IfIdInst(IfIdInst),
        .IfIdValid(IfIdValid),
        .FlushEx(FlushEx),
        .FlushCount(FlushCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM contents: ori-style words unique per word address.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        return 32'h3421_0000 | {16'h0000, a[17:2]};
    endfunction

    // Combinational ROM read.
    assign InstData = romWord(InstAddr);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] perfAdd(input logic [15:0] c, input int n);
`ifdef FETCH_PERF_CNT_EN
        int s;
        s = int'(c) + n;
        return (s > 65535) ? 16'hFFFF : 16'(s);
`else
        return 16'h0000 + 16'(0 * n) + (c & 16'h0000);
`endif
    endfunction

    task automatic modelReset();
        mPc    = 32'h0000_0000;
        mPc4   = 32'h0000_0000;
        mInst  = 32'h0000_0000;
        mValid = 1'b0;
        mCnt   = 16'h0000;
    endtask

    // Drive one cycle, predict the next state, push it, then compare after the edge.
    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                                 input logic jmp, input logic [25:0] idx);
        expT e;
        Stall        = st;
        BranchTaken  = br;
        BranchTarget = tgt;
        Jump         = jmp;
        JumpIndex    = idx;
        if (br) begin
            mPc    = {tgt[31:2], 2'b00};
            mPc4   = 32'h0;
            mInst  = 32'h0;
            mValid = 1'b0;
            mCnt   = perfAdd(mCnt, 2);
        end else if (st) begin
            mPc = mPc;
        end else if (jmp && mValid) begin
            mPc    = {mPc4[31:28], idx, 2'b00};
            mPc4   = 32'h0;
            mInst  = 32'h0;
            mValid = 1'b0;
            mCnt   = perfAdd(mCnt, 1);
        end else begin
            mInst  = romWord(mPc);
            mPc    = mPc + 32'd4;
            mPc4   = mPc;
            mValid = 1'b1;
        end
        e.pc = mPc; e.pc4 = mPc4; e.inst = mInst; e.valid = mValid; e.cnt = mCnt;
        sb.push_back(e);
        #2;
        checkOutput("flushEx", {31'd0, FlushEx}, {31'd0, br});
        @(posedge Clk);
        #1;
        checkOutput_pop();
    endtask

    task automatic checkOutput_pop();
        expT e;
        if (sb.size() == 0) begin
            checkOutput("sbEmpty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("instAddr", InstAddr, e.pc);
            checkOutput("ifIdInst", IfIdInst, e.inst);
            checkOutput("ifIdPc4", IfIdPC4, e.pc4);
            checkOutput("ifIdValid", {31'd0, IfIdValid}, {31'd0, e.valid});
            checkOutput("flushCount", {16'd0, FlushCount}, {16'd0, e.cnt});
        end
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        Jump = 1'b0; JumpIndex = 26'h0;
        modelReset();

        // Reset state
        #2;
        checkOutput("rstAddr", InstAddr, 32'h0);
        checkOutput("rstValid", {31'd0, IfIdValid}, 32'd0);
        checkOutput("rstFlushEx", {31'd0, FlushEx}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        checkOutput("rstHoldAddr", InstAddr, 32'h0);
        Reset = 1'b0;

        // First edge after reset brings ROM[0] into ID
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("firstInst", IfIdInst, romWord(32'h0));
        checkOutput("firstPc4", IfIdPC4, 32'h4);

        // Straight-line fetch up to PC=0x24
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("preBrAddr", InstAddr, 32'h24);

        // Taken branch to 0x28
        applyStimulus(0, 1, 32'h28, 0, 0);
        checkOutput("brPc", InstAddr, 32'h28);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("brTargetInst", IfIdInst, romWord(32'h28));
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("jPc4", IfIdPC4, 32'h30);

        // Jump to index 14 -> 0x38
        applyStimulus(0, 0, 0, 1, 26'd14);
        checkOutput("jPc", InstAddr, 32'h38);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        // Get to PC=0x10 with a valid instruction in ID, then stall 3 cycles
        applyStimulus(0, 1, 32'h0C, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("stallPc", InstAddr, 32'h10);

        // Jump held during stall, taken once stall drops
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 1, 26'd5);
        applyStimulus(0, 0, 0, 1, 26'd5);
        checkOutput("stallJPc", InstAddr, 32'h14);
        applyStimulus(0, 0, 0, 0, 0);

        // Branch during stall redirects immediately
        applyStimulus(1, 1, 32'h40, 0, 0);
        checkOutput("stallBrPc", InstAddr, 32'h40);

        // Jump on a bubble is ignored; branch beats jump in the same cycle
        applyStimulus(0, 0, 0, 1, 26'd3);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h83, 1, 26'd7);
        checkOutput("brBeatsJ", InstAddr, 32'h80);
        applyStimulus(0, 0, 0, 0, 0);

        // PC wraps from 0xFFFF_FFFC to 0
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("wrapPc", InstAddr, 32'h0);
        checkOutput("wrapPc4", IfIdPC4, 32'h0);
        applyStimulus(0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle during a redirect
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("arstAddr", InstAddr, 32'h0);
        checkOutput("arstValid", {31'd0, IfIdValid}, 32'd0);
        checkOutput("arstInst", IfIdInst, 32'h0);
        checkOutput("arstFlushEx", {31'd0, FlushEx}, 32'd0);
        checkOutput("arstCnt", {16'd0, FlushCount}, 32'd0);
        BranchTaken = 1'b0;
        Reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

`ifdef FETCH_PERF_CNT_EN
        // Counter saturates instead of wrapping
        BranchTaken = 1'b1; BranchTarget = 32'h0;
        repeat (32770) @(posedge Clk);
        #1;
        BranchTaken = 1'b0;
        checkOutput("cntSat", {16'd0, FlushCount}, 32'h0000_FFFF);
`endif

        checkOutput("sbDrained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
